tinyqv_periph_arbiter: RTL

- Shares the peripheral (non-memory) data bus between two masters: m0 = CPU data port, m1 = secondary master (DMA or debug).
- Uses round-robin arbitration. Latches the granted request, drives the bus registered, and holds it until `data_ready`.
- Returns read data and a single-cycle ready pulse to the granted master.
- Sits between the CPU's non-memory path and the external `data_*` interface of the tinyQV wrapper.

---
 rtl/tinyqv_periph_arbiter_pkg.sv | 26 ++
 rtl/tinyqv_periph_arbiter_if.sv | 24 ++
 rtl/tinyqv_periph_arbiter_rr_arb2.sv | 23 ++
 rtl/tinyqv_periph_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/tinyqv_periph_arbiter_pkg.sv
// tinyQV peripheral arbiter: shared types and constants.
// Bus size encodings, FSM states and the timeout error word.
package tinyqv_periph_pkg;

  localparam logic [1:0] SIZE_NONE = 2'b11;
  localparam logic [1:0] SIZE_8    = 2'b00;
  localparam logic [1:0] SIZE_16   = 2'b01;
  localparam logic [1:0] SIZE_32   = 2'b10;

  localparam logic [31:0] TIMEOUT_ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_req(
    input logic [1:0] write_n,
    input logic [1:0] read_n
  );
    return (write_n != SIZE_NONE) ||
           (read_n != SIZE_NONE);
  endfunction

endpackage

// File: rtl/tinyqv_periph_arbiter_if.sv
// tinyQV peripheral bus bundle: one requester/completer link.
// master drives the request, slave returns ready and read data.
interface tinyqv_periph_if #(
  parameter int ADDR_W = 28
) ();

  logic [ADDR_W-1:0] addr;
  logic [1:0]        write_n;
  logic [1:0]        read_n;
  logic [31:0]       wdata;
  logic              ready;
  logic [31:0]       rdata;

  modport master (
    output addr, write_n, read_n, wdata,
    input  ready, rdata
  );

  modport slave (
    input  addr, write_n, read_n, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/tinyqv_periph_arbiter_rr_arb2.sv
// tinyQV peripheral arbiter: 2-way round-robin pick.
// On a tie the master that did not win last time is chosen.
module tinyqv_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  assign valid = req0 | req1;

  // pick the sole requester, or alternate on a tie
  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req0 && req1):  grant = ~last_grant;
      (req1 && !req0): grant = 1'b1;
      default:         grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/tinyqv_periph_arbiter.sv
// tinyQV peripheral bus arbiter: CPU (m0) vs DMA/debug (m1).
// Optional bus timeout: define TINYQV_PERIPH_TIMEOUT_EN.
module tinyqv_periph_arbiter
  import tinyqv_periph_pkg::*;
#(
  parameter int ADDR_W         = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rstn,
  tinyqv_periph_if.slave  m0,
  tinyqv_periph_if.slave  m1,
  tinyqv_periph_if.master data,
  output logic bus_err
);

  state_t            state;
  logic              last_grant;
  logic              gnt;
  logic              req0;
  logic              req1;
  logic              pick;
  logic              pick_vld;
  logic              tmo;
  logic [31:0]       ret_data;

  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        bus_wr;
  logic [1:0]        bus_rd;
  logic [31:0]       bus_out;
  logic [1:0]        rdy;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;

  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_wr;
  logic [1:0]        sel_rd;
  logic [31:0]       sel_wdata;

  assign req0 = is_req(m0.write_n, m0.read_n);
  assign req1 = is_req(m1.write_n, m1.read_n);

  tinyqv_rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_vld)
  );

  // select the winner's request; write beats read
  always_comb begin
    sel_addr  = m0.addr;
    sel_wr    = m0.write_n;
    sel_rd    = m0.read_n;
    sel_wdata = m0.wdata;
    if (pick) begin
      sel_addr  = m1.addr;
      sel_wr    = m1.write_n;
      sel_rd    = m1.read_n;
      sel_wdata = m1.wdata;
    end
    if (sel_wr != SIZE_NONE) begin
      sel_rd = SIZE_NONE;
    end
  end

`ifdef TINYQV_PERIPH_TIMEOUT_EN
  localparam int CNT_W =
    (TIMEOUT_CYCLES > 255) ?
    $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt;

  assign tmo = (state == BUSY) && !data.ready &&
               (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // count BUSY cycles spent waiting on the slave
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (state != BUSY) begin
      cnt <= '0;
    end else if (!data.ready) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign tmo = 1'b0;
`endif

  assign ret_data = data.ready ? data.rdata
                               : TIMEOUT_ERR_DATA;

  // grant, hold the registered bus, return the response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      bus_addr   <= '0;
      bus_wr     <= SIZE_NONE;
      bus_rd     <= SIZE_NONE;
      bus_out    <= '0;
      rdy        <= 2'b00;
      rdata0     <= '0;
      rdata1     <= '0;
      bus_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt        <= pick;
            last_grant <= pick;
            bus_addr   <= sel_addr;
            bus_wr     <= sel_wr;
            bus_rd     <= sel_rd;
            bus_out    <= sel_wdata;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (data.ready || tmo) begin
            bus_wr  <= SIZE_NONE;
            bus_rd  <= SIZE_NONE;
            rdy     <= {gnt, ~gnt};
            bus_err <= tmo;
            if (gnt) rdata1 <= ret_data;
            else     rdata0 <= ret_data;
            state   <= RESP;
          end
        end
        RESP: begin
          rdy     <= 2'b00;
          bus_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data.addr    = bus_addr;
  assign data.write_n = bus_wr;
  assign data.read_n  = bus_rd;
  assign data.wdata   = bus_out;

  assign m0.ready = rdy[0];
  assign m0.rdata = rdata0;
  assign m1.ready = rdy[1];
  assign m1.rdata = rdata1;

endmodule
